regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (power of 2, >=4); AW = log2(DEPTH).
REQ-003 SHALL have parameter NREAD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1; when 1, same-cycle writes are forwarded to reads.
REQ-006 SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst_n.
REQ-007 clk  in  1  clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 we0 / we1  in  1  write enable, port 0 / port 1.
REQ-010 wa0 / wa1  in  AW  write address, port 0 / port 1.
REQ-011 wd0 / wd1  in  WIDTH  write data, port 0 / port 1.
REQ-012 wbe0 / wbe1  in  WIDTH/8  byte enables, port 0 / port 1.
REQ-013 ra  in  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-014 rd  out  NREAD*WIDTH  packed registered read data; port k uses bits [k*WIDTH +: WIDTH].
REQ-015 clr_req  in  1  request a sequential clear of all registers.
REQ-016 clr_busy  out  1  high while the clear engine runs.
REQ-017 clr_done  out  1  single-cycle pulse when the clear completes.

Function
REQ-018 Write: on a clk edge with weN=1 and clr_busy=0, each byte b of register waN with wbeN[b]=1 SHALL take wdN byte b; all other bytes SHALL hold.
REQ-019 Dual-write conflict (wa0==wa1, both enabled): port 1 SHALL win each byte enabled on both ports; a byte enabled on one port only SHALL take that port's data.
REQ-020 ZERO_REG=1: writes to address 0 SHALL be discarded, and every read of address 0 SHALL return 0.
REQ-021 Read: rd port k SHALL present the contents of register ra[k] one cycle after ra is sampled (latency 1, registered output), every cycle, regardless of clr_busy.
REQ-022 BYPASS=1: if a write accepted in the same cycle targets ra[k], rd[k] SHALL return the post-write value with per-byte merge under REQ-019; BYPASS=0: rd[k] SHALL return the pre-write value.
REQ-023 Clear FSM states: IDLE and CLEAR; in IDLE, clr_req=1 SHALL enter CLEAR with index counter 0.
REQ-024 In CLEAR, the engine SHALL write 0 to register[index] each cycle and increment index; after index DEPTH-1 it SHALL return to IDLE, with a clear duration of exactly DEPTH cycles.
REQ-025 clr_busy SHALL be 1 exactly while in CLEAR; clr_done SHALL pulse for one cycle on the edge that returns to IDLE.
REQ-026 clr_req while in CLEAR SHALL be ignored; clr_req held high SHALL start a new clear on the cycle after clr_done.
REQ-027 User writes while clr_busy=1 SHALL be dropped silently; reads during CLEAR SHALL return current array contents, with no bypass of clear writes.
REQ-028 Index arithmetic SHALL be AW bits wide, and the wrap after DEPTH-1 SHALL coincide with the exit from CLEAR.

Reset
REQ-029 rst_n=0 SHALL, asynchronously and independent of clk, clear all registers and rd to 0, force the FSM to IDLE, set the index to 0, and drive clr_busy=0 and clr_done=0.
REQ-030 Reset asserted mid-clear SHALL abort the clear without a clr_done pulse; after release, the block SHALL accept writes on the first clk edge.

Verification
REQ-031 Reset then write reg5=0xDEADBEEF via port 0 with wbe=0xF; next cycle ra[0]=5 -> rd[0]=0xDEADBEEF one cycle later.
REQ-032 Reg3=0x11223344; same cycle port0 wd=0xAAAAAAAA wbe=0x3 and port1 wd=0xBBBBBBBB wbe=0x6, both to 3 -> reg3=0x11BBBBAA.
REQ-033 BYPASS=1: write reg7=0x12345678 while ra[1]=7 -> rd[1]=0x12345678 next cycle; with BYPASS=0 rd[1] shows the old value.
REQ-034 Write 0xFFFFFFFF to reg0 with ZERO_REG=1, then read reg0 -> 0.
REQ-035 Fill all registers, pulse clr_req -> clr_busy high for exactly DEPTH cycles, a write issued mid-clear is dropped, clr_done pulses once, and all registers then read 0.
REQ-036 Assert rst_n=0 asynchronously mid-clear between clock edges -> outputs go to 0 immediately, and no clr_done pulse occurs.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two byte-enabled write ports, NREAD registered read
// ports, optional same-cycle write forwarding and a sequential clear engine.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int NB      = WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we0,
  input  logic [AW-1:0]          wa0,
  input  logic [WIDTH-1:0]       wd0,
  input  logic [NB-1:0]          wbe0,
  input  logic                   we1,
  input  logic [AW-1:0]          wa1,
  input  logic [WIDTH-1:0]       wd1,
  input  logic [NB-1:0]          wbe1,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   clr_done
);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                   state_r;
  logic [AW-1:0]            idx_r;
  logic                     clr_busy_r;
  logic                     clr_done_r;
  logic [WIDTH-1:0]         mem_r     [DEPTH];
  logic [WIDTH-1:0]         mem_nxt_s [DEPTH];
  logic [NREAD*WIDTH-1:0]   rd_r;
  logic [NREAD*WIDTH-1:0]   rd_nxt_s;

  function automatic logic [WIDTH-1:0] byte_merge(
    input logic [WIDTH-1:0] old_v,
    input logic [WIDTH-1:0] new_v,
    input logic [NB-1:0]    be
  );
    logic [WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < NB; b++) begin
      res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Next array image: clear write while busy, otherwise port 0 then port 1 so port 1 wins shared bytes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt_s[i] = mem_r[i];
      if (state_r == CLEAR) begin
        mem_nxt_s[i] = (idx_r == AW'(i)) ? {WIDTH{1'b0}} : mem_r[i];
      end else begin
        mem_nxt_s[i] = (we0 && (wa0 == AW'(i))) ? byte_merge(mem_nxt_s[i], wd0, wbe0) : mem_nxt_s[i];
        mem_nxt_s[i] = (we1 && (wa1 == AW'(i))) ? byte_merge(mem_nxt_s[i], wd1, wbe1) : mem_nxt_s[i];
      end
      if ((ZERO_REG != 0) && (i == 0)) begin
        mem_nxt_s[i] = {WIDTH{1'b0}};
      end else begin
        mem_nxt_s[i] = mem_nxt_s[i];
      end
    end
  end

  // Read mux; forwarding only sees user writes, never clear writes.
  always_comb begin
    rd_nxt_s = {(NREAD*WIDTH){1'b0}};
    for (int k = 0; k < NREAD; k++) begin
      if ((BYPASS != 0) && (state_r == IDLE)) begin
        rd_nxt_s[k*WIDTH +: WIDTH] = mem_nxt_s[ra[k*AW +: AW]];
      end else begin
        rd_nxt_s[k*WIDTH +: WIDTH] = mem_r[ra[k*AW +: AW]];
      end
    end
  end

  // Register array and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      rd_r <= {(NREAD*WIDTH){1'b0}};
    end else begin
      mem_r <= mem_nxt_s;
      rd_r  <= rd_nxt_s;
    end
  end

  // Clear engine: DEPTH cycles in CLEAR, index wrap coincides with the exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= {AW{1'b0}};
      clr_busy_r <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          clr_done_r <= 1'b0;
          idx_r      <= {AW{1'b0}};
          if (clr_req) begin
            state_r    <= CLEAR;
            clr_busy_r <= 1'b1;
          end else begin
            state_r    <= IDLE;
            clr_busy_r <= 1'b0;
          end
        end
        CLEAR: begin
          idx_r <= idx_r + {{(AW-1){1'b0}}, 1'b1};
          if (idx_r == AW'(DEPTH - 1)) begin
            state_r    <= IDLE;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b1;
          end else begin
            state_r    <= CLEAR;
            clr_busy_r <= 1'b1;
            clr_done_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          idx_r      <= {AW{1'b0}};
          clr_busy_r <= 1'b0;
          clr_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign rd       = rd_r;
  assign clr_busy = clr_busy_r;
  assign clr_done = clr_done_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: instance a uses default parameters,
// instance b has BYPASS=0 and ZERO_REG=0 and shares every input with a.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  wa0 = 5'd0, wa1 = 5'd0;
  logic [31:0] wd0 = 32'd0, wd1 = 32'd0;
  logic [3:0]  wbe0 = 4'd0, wbe1 = 4'd0;
  logic [9:0]  ra = 10'd0;
  logic        clr_req = 1'b0;
  logic [63:0] rd_a, rd_b;
  logic        busy_a, busy_b, done_a, done_b;

  int errors = 0;
  int checks = 0;
  int busy_cnt, busyb_cnt, done_cnt, done_at, dn;

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .wbe0(wbe0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .wbe1(wbe1),
    .ra(ra), .rd(rd_a),
    .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
  );

  regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .wbe0(wbe0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .wbe1(wbe1),
    .ra(ra), .rd(rd_b),
    .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_a", rd_a[31:0], 32'h0);
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_done", done_a, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Full write then read
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; wbe0 = 4'hF;
    tick;
    we0 = 1'b0; ra[4:0] = 5'd5;
    tick;
    chk("rd_reg5_a", rd_a[31:0], 32'hDEADBEEF);
    chk("rd_reg5_b", rd_b[31:0], 32'hDEADBEEF);

    // Dual-write conflict with per-byte merge
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11223344; wbe0 = 4'hF;
    tick;
    wd0 = 32'hAAAAAAAA; wbe0 = 4'h3;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hBBBBBBBB; wbe1 = 4'h6;
    ra[4:0] = 5'd3;
    tick;
    chk("conflict_bypass_a", rd_a[31:0], 32'h11BBBBAA);
    chk("conflict_nobyp_b", rd_b[31:0], 32'h11223344);
    we0 = 1'b0; we1 = 1'b0;
    tick;
    chk("conflict_a", rd_a[31:0], 32'h11BBBBAA);
    chk("conflict_b", rd_b[31:0], 32'h11BBBBAA);

    // Same-cycle forwarding on read port 1
    ra[9:5] = 5'd7;
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h12345678; wbe0 = 4'hF;
    tick;
    chk("bypass_a", rd_a[63:32], 32'h12345678);
    chk("nobypass_b", rd_b[63:32], 32'h00000000);
    we0 = 1'b0;
    tick;
    chk("after_write_b", rd_b[63:32], 32'h12345678);

    // Single byte enable on port 1 only
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hCAFEF00D; wbe1 = 4'hF;
    tick;
    wd1 = 32'h55000000; wbe1 = 4'h8; ra[4:0] = 5'd9;
    tick;
    we1 = 1'b0;
    tick;
    chk("byte3_a", rd_a[31:0], 32'h55FEF00D);

    // Register 0 hardwired in a, plain register in b
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; wbe0 = 4'hF; ra[4:0] = 5'd0;
    tick;
    chk("zero_bypass_a", rd_a[31:0], 32'h0);
    we0 = 1'b0;
    tick;
    chk("zero_a", rd_a[31:0], 32'h0);
    chk("reg0_b", rd_b[31:0], 32'hFFFFFFFF);

    // Two ports writing different registers
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h0A0A0A0A; wbe0 = 4'hF;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'h0B0B0B0B; wbe1 = 4'hF;
    ra = {5'd11, 5'd10};
    tick;
    we0 = 1'b0; we1 = 1'b0;
    chk("dual_p0_a", rd_a[31:0], 32'h0A0A0A0A);
    chk("dual_p1_a", rd_a[63:32], 32'h0B0B0B0B);

    // Fill every register
    for (int i = 0; i < 32; i++) begin
      we0 = 1'b1; wa0 = i[4:0]; wd0 = 32'h10000000 + i; wbe0 = 4'hF;
      tick;
    end
    we0 = 1'b0;
    ra = {5'd20, 5'd31};
    tick;
    chk("fill31_a", rd_a[31:0], 32'h1000001F);
    chk("fill20_a", rd_a[63:32], 32'h10000014);
    ra = {5'd20, 5'd0};
    tick;
    chk("fill0_b", rd_b[31:0], 32'h10000000);

    // Clear engine with a write issued mid-clear
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    busy_cnt = 0; busyb_cnt = 0; done_cnt = 0; done_at = -1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (busy_a) busy_cnt++;
      if (busy_b) busyb_cnt++;
      if (done_a) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (cyc == 5) begin
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hFFFFFFFF; wbe0 = 4'hF; ra[4:0] = 5'd31;
      end
      if (cyc == 6) begin
        we0 = 1'b0;
        chk("read_during_clear_a", rd_a[31:0], 32'h1000001F);
      end
      tick;
    end
    chk("clr_busy_cycles_a", busy_cnt, 32'd32);
    chk("clr_busy_cycles_b", busyb_cnt, 32'd32);
    chk("clr_done_count", done_cnt, 32'd1);
    chk("clr_done_time", done_at, 32'd32);
    for (int i = 0; i < 32; i++) begin
      ra[4:0] = i[4:0];
      tick;
      chk("cleared_a", rd_a[31:0], 32'h0);
      if (i < 2) chk("cleared_b", rd_b[31:0], 32'h0);
    end

    // clr_req held high restarts right after clr_done
    clr_req = 1'b1;
    tick;
    chk1("held_busy_start", busy_a, 1'b1);
    repeat (31) tick;
    chk1("held_busy_last", busy_a, 1'b1);
    chk1("held_done_early", done_a, 1'b0);
    tick;
    chk1("held_busy_exit", busy_a, 1'b0);
    chk1("held_done_pulse", done_a, 1'b1);
    tick;
    chk1("held_restart_busy", busy_a, 1'b1);
    chk1("held_restart_done", done_a, 1'b0);
    clr_req = 1'b0;
    repeat (40) tick;
    chk1("held_finished", busy_a, 1'b0);

    // Asynchronous reset in the middle of a clear
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hA5A5A5A5; wbe0 = 4'hF; ra[4:0] = 5'd4;
    tick;
    we0 = 1'b0;
    tick;
    chk("pre_abort_b", rd_b[31:0], 32'hA5A5A5A5);
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    repeat (3) tick;
    chk1("abort_busy_before", busy_a, 1'b1);
    chk("abort_rd_before", rd_a[31:0], 32'hA5A5A5A5);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd_a", rd_a[31:0], 32'h0);
    chk("abort_rd_b", rd_b[31:0], 32'h0);
    chk1("abort_busy_a", busy_a, 1'b0);
    chk1("abort_busy_b", busy_b, 1'b0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a || done_b) dn++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h600DF00D; wbe0 = 4'hF; ra[4:0] = 5'd6;
    tick;
    we0 = 1'b0;
    if (done_a || done_b) dn++;
    chk("post_rst_bypass_a", rd_a[31:0], 32'h600DF00D);
    tick;
    if (done_a || done_b) dn++;
    chk("post_rst_write_b", rd_b[31:0], 32'h600DF00D);
    chk1("post_rst_busy", busy_a, 1'b0);
    chk("abort_no_done", dn, 32'd0);
    ra[4:0] = 5'd4;
    tick;
    chk("rst_cleared_reg4_b", rd_b[31:0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
